mem_responder: RTL and testbench

Memory-side responder for the CPU control unit's access strobes. It accepts one-cycle `inst_wr` (instruction fetch), `mem_rd` and `mem_wr` requests, inserts a configurable number of wait states, and performs the access on an internal single-port word array. It returns fetched instructions in an instruction register, read data in a data register, and signals completion back to the sequencer. It sits between the control unit and the datapath register file/PC.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: request/FSM enums and default widths for the control unit and memory responder.
// MEM_RESPONDER_PARITY_EN adds one even-parity bit per stored word.
package cpu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;

`ifdef MEM_RESPONDER_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_FETCH,
      REQ_READ,
      REQ_WRITE
   } req_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read and no reset.
// Word width is DATA_W plus the parity bit when MEM_RESPONDER_PARITY_EN is defined.
module mem_array
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W+PAR_W-1:0]  wdata,
   output logic [DATA_W+PAR_W-1:0]  rdata
);

   logic [DATA_W+PAR_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serialises fetch/read/write strobes with WAIT_CYCLES wait states onto mem_array.
// MEM_RESPONDER_PARITY_EN enables stored even parity and the sticky parity_err flag.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inst_wr,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] inst,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              collide,
   output logic              parity_err
);

   localparam int         MEM_W    = DATA_W + PAR_W;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state, state_nxt;
   req_t              req, req_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              done_nxt, collide_nxt, capture;
   logic [1:0]        n_strobes;
   logic [ADDR_W-1:0] addr_q, ram_addr;
   logic [DATA_W-1:0] data_q;
   logic              ram_we;
   logic [MEM_W-1:0]  ram_wdata, ram_rdata;

`ifdef MEM_RESPONDER_PARITY_EN
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   assign n_strobes = 2'(inst_wr) + 2'(mem_rd) + 2'(mem_wr);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      req_nxt     = req;
      cnt_nxt     = cnt;
      capture     = 1'b0;
      done_nxt    = 1'b0;
      collide_nxt = 1'b0;
      ram_addr    = addr_q;
      case (state)
         IDLE: begin
            // The RAM reads the incoming address here so a zero-wait access has its word ready in ACCESS.
            ram_addr    = inst_wr ? pc_addr : data_addr;
            collide_nxt = (n_strobes > 2'd1);
            if (inst_wr)     req_nxt = REQ_FETCH;
            else if (mem_rd) req_nxt = REQ_READ;
            else if (mem_wr) req_nxt = REQ_WRITE;
            else             req_nxt = REQ_NONE;
            if (n_strobes != 2'd0) begin
               capture = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt = ACCESS;
               end
            end
         end
         WAIT: begin
            collide_nxt = (n_strobes != 2'd0);
            if (cnt == 4'd0) state_nxt = ACCESS;
            else             cnt_nxt   = cnt - 4'd1;
         end
         ACCESS: begin
            collide_nxt = (n_strobes != 2'd0);
            done_nxt    = 1'b1;
            req_nxt     = REQ_NONE;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ram_we = (state == ACCESS) && (req == REQ_WRITE);

`ifdef MEM_RESPONDER_PARITY_EN
   assign ram_wdata = {even_parity(data_q), data_q};
`else
   assign ram_wdata = data_q;
`endif

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clock (clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         req     <= REQ_NONE;
         cnt     <= 4'd0;
         done    <= 1'b0;
         collide <= 1'b0;
         inst    <= '0;
         rd_data <= '0;
      end else begin
         state   <= state_nxt;
         req     <= req_nxt;
         cnt     <= cnt_nxt;
         done    <= done_nxt;
         collide <= collide_nxt;
         if (state == ACCESS && req == REQ_FETCH) inst    <= ram_rdata[DATA_W-1:0];
         if (state == ACCESS && req == REQ_READ)  rd_data <= ram_rdata[DATA_W-1:0];
      end
   end

   // Captured request operands are held so input changes during WAIT cannot disturb the access.
   always_ff @(posedge clock) begin
      if (capture) begin
         addr_q <= ram_addr;
         data_q <= wr_data;
      end
   end

`ifdef MEM_RESPONDER_PARITY_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else if (state == ACCESS && req != REQ_WRITE && (^ram_rdata)) begin
         parity_err <= 1'b1;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, directed multi-cycle sequences and a randomized model check.
module tb_mem_responder;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int W  = 1;

`ifdef MEM_RESPONDER_PARITY_EN
   localparam logic PAR_ON = 1'b1;
`else
   localparam logic PAR_ON = 1'b0;
`endif

   logic          clock, reset;
   logic          inst_wr, mem_rd, mem_wr;
   logic [AW-1:0] pc_addr, data_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] inst, rd_data;
   logic          busy, done, collide, parity_err;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model_mem [0:(1<<AW)-1];

   typedef struct {
      logic          iw, rd, wr;
      logic [AW-1:0] pc, da;
      logic [DW-1:0] wd, e_inst, e_rd;
      logic          e_col;
   } vec_t;

   vec_t vecs [12];

   mem_responder #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .WAIT_CYCLES (W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .inst_wr    (inst_wr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .pc_addr    (pc_addr),
      .data_addr  (data_addr),
      .wr_data    (wr_data),
      .inst       (inst),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .collide    (collide),
      .parity_err (parity_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
      return {a, ~a};
   endfunction

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
      model_mem[a] = v;
`ifdef MEM_RESPONDER_PARITY_EN
      dut.u_array.mem[a] = {^v, v};
`else
      dut.u_array.mem[a] = v;
`endif
   endtask

   task automatic preload_all();
      for (int i = 0; i < (1 << AW); i++) preload(AW'(i), fill(AW'(i)));
      preload(8'h03, 16'hA5C3);
      preload(8'h20, 16'h0000);
   endtask

   task automatic clear_inputs();
      inst_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      pc_addr = '0; data_addr = '0; wr_data = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   busy_n  = 0;
      int   done_n  = 0;
      int   done_at = -1;
      int   col_n   = 0;
      logic col0    = 1'b0;
      tick();
      inst_wr = v.iw; mem_rd = v.rd; mem_wr = v.wr;
      pc_addr = v.pc; data_addr = v.da; wr_data = v.wd;
      tick();
      inst_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      pc_addr = AW'($urandom); data_addr = AW'($urandom); wr_data = DW'($urandom);
      for (int s = 0; s < W + 4; s++) begin
         @(negedge clock);
         if (s == 0) col0 = collide;
         else if (collide) col_n++;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = s;
         end
      end
      check({tag, "_collide"}, 64'(col0), 64'(v.e_col));
      check({tag, "_collide_extra"}, 64'(col_n), 64'd0);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_latency"}, 64'(done_at), 64'(W + 1));
      check({tag, "_inst"}, 64'(inst), 64'(v.e_inst));
      check({tag, "_rd_data"}, 64'(rd_data), 64'(v.e_rd));
      clear_inputs();
   endtask

   initial begin
      logic          a, b, d;
      logic [AW-1:0] pa, da, paddr;
      logic [DW-1:0] wd, pdata, m_inst, m_rd;
      logic          pend, m_done, m_col;
      int            rem, ptype, ns;
      int            dn;
      vec_t          r;

      clear_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      preload_all();

      check("rst_inst", 64'(inst), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_collide", 64'(collide), 64'd0);
      check("rst_parity_err", 64'(parity_err), 64'd0);

      //             iw    rd    wr    pc     da     wd        e_inst    e_rd      e_col
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 16'h0000, 16'hA5C3, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 16'h1234, 16'hA5C3, 16'h0000, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 16'h0000, 16'hA5C3, 16'h1234, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 16'h0000, 16'hA5C3, 16'h11EE, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h40, 8'h50, 16'hDEAD, 16'h40BF, 16'h11EE, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h50, 16'h0000, 16'h40BF, 16'h50AF, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 16'hBEEF, 16'h40BF, 16'h22DD, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h23, 16'h0000, 16'h40BF, 16'h23DC, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 16'h0000, 16'h40BF, 16'h22DD, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 16'h0F0F, 16'h40BF, 16'h22DD, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0000, 16'h0F0F, 16'h22DD, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 16'h7777, 16'h00FF, 16'h22DD, 1'b1};

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // write then read issued in the done cycle
      tick();
      mem_wr = 1'b1; data_addr = 8'h10; wr_data = 16'h4321;
      tick();
      mem_wr = 1'b0; data_addr = 8'h77; wr_data = 16'h0000;
      repeat (W + 1) tick();
      check("wr_done_pulse", 64'(done), 64'd1);
      mem_rd = 1'b1; data_addr = 8'h10;
      tick();
      mem_rd = 1'b0;
      check("rd_in_done_collide", 64'(collide), 64'd0);
      check("rd_in_done_busy", 64'(busy), 64'd1);
      repeat (W + 1) tick();
      check("rd_in_done_pulse", 64'(done), 64'd1);
      check("rd_in_done_data", 64'(rd_data), 64'h4321);

      // read while busy is dropped
      tick();
      inst_wr = 1'b1; pc_addr = 8'h03;
      tick();
      inst_wr = 1'b0; mem_rd = 1'b1; data_addr = 8'h11;
      tick();
      mem_rd = 1'b0;
      check("busy_rd_collide", 64'(collide), 64'd1);
      check("busy_rd_busy", 64'(busy), 64'd1);
      repeat (W) tick();
      check("busy_rd_done", 64'(done), 64'd1);
      check("busy_rd_inst", 64'(inst), 64'hA5C3);
      check("busy_rd_rd_data", 64'(rd_data), 64'h4321);
      dn = 0;
      repeat (4) begin
         tick();
         if (done) dn++;
      end
      check("busy_rd_no_second_done", 64'(dn), 64'd0);

      // reset during WAIT aborts a write
      tick();
      mem_wr = 1'b1; data_addr = 8'h20; wr_data = 16'hFFFF;
      tick();
      mem_wr = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("abort_inst", 64'(inst), 64'd0);
      check("abort_rd_data", 64'(rd_data), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_collide", 64'(collide), 64'd0);
      check("abort_parity_err", 64'(parity_err), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      r = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      run_vec(r, "abort_readback");

      // corrupted stored word
      dut.u_array.mem[5][3] = ~dut.u_array.mem[5][3];
      r = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 16'h0000, 16'h0000, 16'h05F2, 1'b0};
      run_vec(r, "par_read");
      check("par_flag", 64'(parity_err), 64'(PAR_ON));
      r = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 16'h0000, 16'h0000, 16'h4321, 1'b0};
      run_vec(r, "par_clean_read");
      check("par_sticky", 64'(parity_err), 64'(PAR_ON));
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      check("par_cleared", 64'(parity_err), 64'd0);

      // randomized traffic against a transaction-level model
      preload_all();
      m_inst = '0; m_rd = '0; pend = 1'b0; rem = 0; ptype = 0;
      paddr = '0; pdata = '0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 99) < 45) {a, b, d} = 3'($urandom);
         else {a, b, d} = 3'b000;
         pa = AW'($urandom_range(0, 15));
         da = AW'($urandom_range(0, 15));
         wd = DW'($urandom);
         inst_wr = a; mem_rd = b; mem_wr = d;
         pc_addr = pa; data_addr = da; wr_data = wd;
         @(posedge clock);
         ns = int'(a) + int'(b) + int'(d);
         m_done = 1'b0;
         m_col  = 1'b0;
         if (pend) begin
            m_col = (ns > 0);
            rem--;
            if (rem == 0) begin
               if (ptype == 0)      m_inst = model_mem[paddr];
               else if (ptype == 1) m_rd   = model_mem[paddr];
               else                 model_mem[paddr] = pdata;
               pend   = 1'b0;
               m_done = 1'b1;
            end
         end else if (ns > 0) begin
            m_col = (ns > 1);
            pend  = 1'b1;
            rem   = W + 1;
            if (a)      begin ptype = 0; paddr = pa; end
            else if (b) begin ptype = 1; paddr = da; end
            else        begin ptype = 2; paddr = da; pdata = wd; end
         end
         #1;
         check($sformatf("rand%0d", c),
               {28'd0, inst, rd_data, busy, done, collide, parity_err},
               {28'd0, m_inst, m_rd, pend, m_done, m_col, 1'b0});
      end
      clear_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
